// File: rtl/axis_frame_tlast.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : axis_frame_tlast
// Brief   : AXI-Stream framer. Counts beats, tags TLAST on the last beat of
//           each programmed frame, through a registered 2-entry skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
module axis_frame_tlast #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESETN,
  input  logic                enable,
  input  logic [CNT_W-1:0]    frame_len,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TSTRB,
  input  logic                S_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TSTRB,
  output logic                M_AXIS_TLAST,
  output logic                busy,
  output logic [CNT_W-1:0]    frames_done,
  output logic                err_len_zero
);

  localparam int               c_strb_w = DATA_W / 8;
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_remaining;
  logic [CNT_W-1:0]    w_remaining_nxt;
  logic                w_beat_last;
  logic                w_len_err;
  logic [CNT_W-1:0]    w_len_eff;

  logic                r_s_ready;
  logic                r_out_valid;
  logic                r_out_last;
  logic [DATA_W-1:0]   r_out_data;
  logic [c_strb_w-1:0] r_out_strb;
  logic                r_skid_valid;
  logic                r_skid_last;
  logic [DATA_W-1:0]   r_skid_data;
  logic [c_strb_w-1:0] r_skid_strb;
  logic [CNT_W-1:0]    r_frames_done;
  logic                r_err_len_zero;

  logic                w_s_fire;
  logic                w_m_fire;
  logic                w_out_free;
  logic                w_skid_valid_nxt;
  logic                w_accept_ok;
  logic                w_unused;

  // Upstream TLAST is meaningless here; framing comes solely from frame_len.
  assign w_unused = S_AXIS_TLAST;

  assign w_s_fire   = S_AXIS_TVALID & r_s_ready;
  assign w_m_fire   = r_out_valid & M_AXIS_TREADY;
  assign w_out_free = ~r_out_valid | M_AXIS_TREADY;
  assign w_len_eff  = (frame_len == '0) ? c_one : frame_len;

  // r_remaining holds the beats still owed after the last accepted one.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_beat_last     = 1'b0;
    w_len_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_beat_last = (w_len_eff == c_one);
        if (w_s_fire) begin
          w_len_err = (frame_len == '0);
          if (!w_beat_last) begin
            w_state_nxt     = ST_RUN;
            w_remaining_nxt = w_len_eff - c_one;
          end
        end
      end
      ST_RUN: begin
        w_beat_last = (r_remaining == c_one);
        if (w_s_fire) begin
          w_remaining_nxt = r_remaining - c_one;
          if (w_beat_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Ready is precomputed for the next cycle so it never depends on M_AXIS_TREADY.
  always_comb begin
    w_skid_valid_nxt = 1'b0;
    if (r_skid_valid) begin
      w_skid_valid_nxt = ~w_out_free;
    end else begin
      w_skid_valid_nxt = w_s_fire & ~w_out_free;
    end
  end

  assign w_accept_ok = (w_state_nxt == ST_RUN) | enable;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_s_ready      <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_last    <= 1'b0;
      r_frames_done  <= '0;
      r_err_len_zero <= 1'b0;
    end else begin
      r_s_ready <= ~w_skid_valid_nxt & w_accept_ok;
      if (r_skid_valid) begin
        if (w_out_free) begin
          r_out_valid  <= 1'b1;
          r_out_last   <= r_skid_last;
          r_skid_valid <= 1'b0;
        end
      end else if (w_s_fire) begin
        if (w_out_free) begin
          r_out_valid <= 1'b1;
          r_out_last  <= w_beat_last;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_last  <= w_beat_last;
        end
      end else if (w_m_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_m_fire && r_out_last) begin
        r_frames_done <= r_frames_done + c_one;
      end
      if (w_len_err) begin
        r_err_len_zero <= 1'b1;
      end
    end
  end

  // Payload registers need no reset; their contents are only seen under TVALID.
  always_ff @(posedge AXIS_ACLK) begin
    if (r_skid_valid) begin
      if (w_out_free) begin
        r_out_data <= r_skid_data;
        r_out_strb <= r_skid_strb;
      end
    end else if (w_s_fire) begin
      if (w_out_free) begin
        r_out_data <= S_AXIS_TDATA;
        r_out_strb <= S_AXIS_TSTRB;
      end else begin
        r_skid_data <= S_AXIS_TDATA;
        r_skid_strb <= S_AXIS_TSTRB;
      end
    end
  end

  assign S_AXIS_TREADY = r_s_ready;
  assign M_AXIS_TVALID = r_out_valid;
  assign M_AXIS_TDATA  = r_out_data;
  assign M_AXIS_TSTRB  = r_out_strb;
  assign M_AXIS_TLAST  = r_out_last;
  assign busy          = (r_state == ST_RUN) | r_out_valid | r_skid_valid;
  assign frames_done   = r_frames_done;
  assign err_len_zero  = r_err_len_zero;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_tlast.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_axis_frame_tlast
// Brief   : Directed scoreboard bench for axis_frame_tlast.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axis_frame_tlast;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [CNT_W-1:0]  frame_len;
  logic              s_tvalid, s_tready, s_tlast;
  logic [DATA_W-1:0] s_tdata;
  logic [7:0]        s_tstrb;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic [7:0]        m_tstrb;
  logic              busy;
  logic [CNT_W-1:0]  frames_done;
  logic              err_len_zero;

  always #5 clk = ~clk;

  axis_frame_tlast #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .enable        (enable),
    .frame_len     (frame_len),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TLAST  (m_tlast),
    .busy          (busy),
    .frames_done   (frames_done),
    .err_len_zero  (err_len_zero)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
    time         t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   stalls   = 0;
  bit   chk_lat  = 1'b0;
  bit   t2_on    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each M-side transfer, checks stall stability.
  exp_t        e;
  logic        hold_v = 1'b0;
  logic [63:0] hold_d;
  logic [8:0]  hold_sl;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("m_stall_valid", 64'(m_tvalid), 64'd1);
        chk("m_stall_data", m_tdata, hold_d);
        chk("m_stall_strb_last", 64'({m_tstrb, m_tlast}), 64'(hold_sl));
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          chk("m_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("m_data", m_tdata, e.d);
          chk("m_strb", 64'(m_tstrb), 64'(e.s));
          chk("m_tlast", 64'(m_tlast), 64'(e.l));
          if (chk_lat) chk("m_latency_ns", 64'($time - e.t), 64'd10);
        end
        hold_v = 1'b0;
      end else if (m_tvalid) begin
        hold_v  = 1'b1;
        hold_d  = m_tdata;
        hold_sl = {m_tstrb, m_tlast};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] s, input logic l);
    int w = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = s;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      stalls++;
      w++;
      if (w > 200) begin
        chk("s_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (s_tready) q.push_back('{d, s, l, $time});
    @(posedge clk);
    #1;
  endtask

  task automatic s_idle();
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_tvalid) break;
    end
    chk(name, 64'(i < 1000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    frame_len = '0;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tstrb   = '0;
    s_tlast   = 1'b0;
    m_tready  = 1'b0;
    #12;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frames_done", 64'(frames_done), 64'd0);
    chk("rst_err_len_zero", 64'(err_len_zero), 64'd0);

    // T1: frame_len=4, 8 beats, no backpressure; upstream TLAST held high and ignored.
    enable    = 1'b1;
    frame_len = 16'd4;
    m_tready  = 1'b1;
    s_tlast   = 1'b1;
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] sb;
      sb = 8'hFF >> i;
      send(64'hD000_0000_0000_0000 | 64'(i), sb, (i % 4) == 3);
      if (i == 0) stalls = 0;
    end
    s_idle();
    chk("t1_no_s_stall", 64'(stalls), 64'd0);
    drain("t1_drain");
    chk_lat = 1'b0;
    chk("t1_frames_done", 64'(frames_done), 64'd2);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    s_tlast = 1'b0;

    // T2: frame_len=3, 300 beats with random downstream backpressure.
    frame_len = 16'd3;
    do_reset();
    t2_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(64'h2000 + 64'(i), 8'(i), (i % 3) == 2);
        end
        s_idle();
        t2_on = 1'b0;
      end
      begin
        while (t2_on) begin
          m_tready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    m_tready = 1'b1;
    drain("t2_drain");
    chk("t2_frames_done", 64'(frames_done), 64'd100);

    // T3: frame_len=5, enable dropped after beat 2; frame still completes.
    frame_len = 16'd5;
    do_reset();
    send(64'h3000, 8'h01, 1'b0);
    send(64'h3001, 8'h03, 1'b0);
    enable = 1'b0;
    send(64'h3002, 8'h07, 1'b0);
    chk("t3_busy_mid_frame", 64'(busy), 64'd1);
    send(64'h3003, 8'h0F, 1'b0);
    send(64'h3004, 8'h1F, 1'b1);
    s_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_ready_low", 64'(s_tready), 64'd0);
    end
    enable = 1'b1;
    begin
      int w;
      for (w = 0; w < 10; w++) begin
        @(negedge clk);
        if (s_tready) break;
      end
      chk("t3_ready_back", 64'(s_tready), 64'd1);
    end
    drain("t3_drain");
    chk("t3_frames_done", 64'(frames_done), 64'd1);

    // T4: frame_len=0 then 1: every beat is last; error is sticky.
    frame_len = 16'd0;
    do_reset();
    chk("t4_err_clear", 64'(err_len_zero), 64'd0);
    send(64'h4000, 8'hAA, 1'b1);
    frame_len = 16'd1;
    chk("t4_err_set", 64'(err_len_zero), 64'd1);
    send(64'h4001, 8'h55, 1'b1);
    send(64'h4002, 8'hF0, 1'b1);
    send(64'h4003, 8'h0F, 1'b1);
    s_idle();
    drain("t4_drain");
    chk("t4_err_sticky", 64'(err_len_zero), 64'd1);
    chk("t4_frames_done", 64'(frames_done), 64'd4);

    // T5: frame_len=2 at the first beat, changed to 6 mid-frame.
    frame_len = 16'd2;
    do_reset();
    send(64'h5000, 8'hFF, 1'b0);
    frame_len = 16'd6;
    send(64'h5001, 8'hFF, 1'b1);
    for (int i = 2; i < 8; i++) begin
      send(64'h5000 + 64'(i), 8'hFF, i == 7);
    end
    s_idle();
    drain("t5_drain");
    chk("t5_frames_done", 64'(frames_done), 64'd2);

    // T6: async reset with both buffer entries full.
    frame_len = 16'd8;
    do_reset();
    m_tready = 1'b0;
    send(64'h6000, 8'h11, 1'b0);
    send(64'h6001, 8'h22, 1'b0);
    s_idle();
    @(negedge clk);
    chk("t6_full_s_tready", 64'(s_tready), 64'd0);
    chk("t6_full_m_tvalid", 64'(m_tvalid), 64'd1);
    chk("t6_full_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    #1;
    chk("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_s_tready", 64'(s_tready), 64'd0);
    chk("t6_rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_frames_done", 64'(frames_done), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_len = 16'd2;
    m_tready  = 1'b1;
    send(64'h6100, 8'h33, 1'b0);
    send(64'h6101, 8'h44, 1'b1);
    s_idle();
    drain("t6_drain");
    chk("t6_frames_done", 64'(frames_done), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
